vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from a 25 MHz pixel clock.
- Outputs include:
  - horizontal and vertical sync;
  - a display-active flag;
  - current pixel coordinates;
  - a one-cycle end-of-frame strobe.
- Sits between the 4x clock divider and the pixel pipeline. The pipeline uses x/y to address image memory, and game logic uses screenEnd to advance once per frame.

---
 rtl/vga_timing_gen.sv | 64 ++++++
 tb/tb_vga_timing_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: free-running pixel/line counters with
// combinational decode of syncs, visible-region flag, coordinates and frame strobe.
module vga_timing_gen #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33
) (
    input  logic       clk25,
    input  logic       reset,
    output logic       screenEnd,
    output logic       active,
    output logic       hSync,
    output logic       vSync,
    output logic [9:0] x,
    output logic [8:0] y
);
    localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

    // Thresholds pre-sized to the counter width so every compare is 10 bits.
    localparam logic [9:0] H_VIS   = 10'(WIDTH);
    localparam logic [9:0] H_SS    = 10'(WIDTH + H_FRONT);
    localparam logic [9:0] H_SE    = 10'(WIDTH + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS   = 10'(HEIGHT);
    localparam logic [9:0] V_SS    = 10'(HEIGHT + V_FRONT);
    localparam logic [9:0] V_SE    = 10'(HEIGHT + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       h_vis;
    logic       v_vis;

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    assign h_vis = (h_count < H_VIS);
    assign v_vis = (v_count < V_VIS);

    always_comb begin
        active    = h_vis && v_vis;
        hSync     = !((h_count >= H_SS) && (h_count < H_SE));
        vSync     = !((v_count >= V_SS) && (v_count < V_SE));
        x         = h_vis ? h_count : '0;
        // Full 10-bit compare above keeps rows 512..524 from aliasing into y.
        y         = v_vis ? v_count[8:0] : '0;
        screenEnd = (h_count == '0) && (v_count == V_VIS);
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-timing instance for line-level checks plus a shrunken-timing
// instance so several whole frames fit in a short run.
module tb_vga_timing_gen;
    localparam int SW = 16, SHF = 4, SHS = 6, SHB = 4;
    localparam int SH = 8,  SVF = 2, SVS = 2, SVB = 3;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       act;
        logic       hs;
        logic       vs;
        logic       se;
    } out_t;

    typedef struct {
        int   inst;
        int   n;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [9:0] xd, xs;
    logic [8:0] yd, ys;
    logic ad, hd, vd, sd, as_, hs_, vs_, ss;
    out_t od, os;

    int checks = 0;
    int passed = 0;
    int n = 0;
    bit running = 1'b0;
    int act_cnt = 0, vs_cnt = 0, se_cnt = 0, hs_cnt = 0;
    out_t qd[$];
    out_t qs[$];
    vec_t tbl[28];

    always #5 clk = ~clk;

    vga_timing_gen dut_def (
        .clk25(clk), .reset(rst_n), .screenEnd(sd), .active(ad),
        .hSync(hd), .vSync(vd), .x(xd), .y(yd)
    );

    vga_timing_gen #(
        .WIDTH(SW), .HEIGHT(SH), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) dut_sm (
        .clk25(clk), .reset(rst_n), .screenEnd(ss), .active(as_),
        .hSync(hs_), .vSync(vs_), .x(xs), .y(ys)
    );

    assign od = {xd, yd, ad, hd, vd, sd};
    assign os = {xs, ys, as_, hs_, vs_, ss};

    // Expected outputs from elapsed cycles since reset release.
    function automatic out_t model(int cyc, int w, int hf, int hsw, int hb,
                                   int h, int vf, int vsw, int vb);
        int ht = w + hf + hsw + hb;
        int vt = h + vf + vsw + vb;
        int hc = cyc % ht;
        int vc = (cyc / ht) % vt;
        out_t o;
        o.x   = (hc < w) ? 10'(hc) : 10'd0;
        o.y   = (vc < h) ? 9'(vc) : 9'd0;
        o.act = (hc < w) && (vc < h);
        o.hs  = !((hc >= w + hf) && (hc < w + hf + hsw));
        o.vs  = !((vc >= h + vf) && (vc < h + vf + vsw));
        o.se  = (hc == 0) && (vc == h);
        return o;
    endfunction

    function automatic out_t mk(int xv, int yv, bit a, bit h, bit v, bit s);
        out_t o;
        o.x = 10'(xv); o.y = 9'(yv); o.act = a; o.hs = h; o.vs = v; o.se = s;
        return o;
    endfunction

    function automatic vec_t row(int inst, int cyc, out_t e);
        vec_t r;
        r.inst = inst; r.n = cyc; r.exp = e;
        return r;
    endfunction

    task automatic chk(input string nm, input out_t got, input out_t exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got x=%0d y=%0d act=%b hs=%b vs=%b se=%b, want x=%0d y=%0d act=%b hs=%b vs=%b se=%b",
                      nm, got.x, got.y, got.act, got.hs, got.vs, got.se,
                      exp.x, exp.y, exp.act, exp.hs, exp.vs, exp.se);
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    endtask

    // Scoreboard producer: every counting edge queues the expected state.
    initial forever begin
        @(posedge clk);
        if (running) begin
            n++;
            qd.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33));
            qs.push_back(model(n, SW, SHF, SHS, SHB, SH, SVF, SVS, SVB));
        end
    end

    // Scoreboard consumer, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (qd.size() > 0) begin
            chk($sformatf("sb_def n=%0d", n), od, qd.pop_front());
            chk($sformatf("sb_sm n=%0d", n), os, qs.pop_front());
            if (n >= 1 && n <= 1350) begin
                act_cnt += int'(as_);
                vs_cnt  += int'(!vs_);
                se_cnt  += int'(ss);
            end
            if (n >= 1 && n <= 800) hs_cnt += int'(!hd);
        end
    end

    initial begin
        int guard;
        out_t rst_val;
        rst_val = mk(0, 0, 1, 1, 1, 0);

        tbl[0]  = row(0, 0,    mk(0,   0, 1, 1, 1, 0));
        tbl[1]  = row(1, 0,    mk(0,   0, 1, 1, 1, 0));
        tbl[2]  = row(0, 1,    mk(1,   0, 1, 1, 1, 0));
        tbl[3]  = row(1, 15,   mk(15,  0, 1, 1, 1, 0));
        tbl[4]  = row(1, 16,   mk(0,   0, 0, 1, 1, 0));
        tbl[5]  = row(1, 20,   mk(0,   0, 0, 0, 1, 0));
        tbl[6]  = row(1, 26,   mk(0,   0, 0, 1, 1, 0));
        tbl[7]  = row(1, 225,  mk(15,  7, 1, 1, 1, 0));
        tbl[8]  = row(1, 239,  mk(0,   7, 0, 1, 1, 0));
        tbl[9]  = row(1, 240,  mk(0,   0, 0, 1, 1, 1));
        tbl[10] = row(1, 241,  mk(1,   0, 0, 1, 1, 0));
        tbl[11] = row(1, 299,  mk(0,   0, 0, 1, 1, 0));
        tbl[12] = row(1, 300,  mk(0,   0, 0, 1, 0, 0));
        tbl[13] = row(1, 359,  mk(0,   0, 0, 1, 0, 0));
        tbl[14] = row(1, 360,  mk(0,   0, 0, 1, 1, 0));
        tbl[15] = row(1, 449,  mk(0,   0, 0, 1, 1, 0));
        tbl[16] = row(1, 450,  mk(0,   0, 1, 1, 1, 0));
        tbl[17] = row(0, 639,  mk(639, 0, 1, 1, 1, 0));
        tbl[18] = row(0, 640,  mk(0,   0, 0, 1, 1, 0));
        tbl[19] = row(0, 655,  mk(0,   0, 0, 1, 1, 0));
        tbl[20] = row(0, 656,  mk(0,   0, 0, 0, 1, 0));
        tbl[21] = row(1, 690,  mk(0,   0, 0, 1, 1, 1));
        tbl[22] = row(0, 751,  mk(0,   0, 0, 0, 1, 0));
        tbl[23] = row(0, 752,  mk(0,   0, 0, 1, 1, 0));
        tbl[24] = row(0, 799,  mk(0,   0, 0, 1, 1, 0));
        tbl[25] = row(0, 800,  mk(0,   1, 1, 1, 1, 0));
        tbl[26] = row(1, 1140, mk(0,   0, 0, 1, 1, 1));
        tbl[27] = row(0, 1439, mk(639, 1, 1, 1, 1, 0));

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_hold_def", od, rst_val);
        chk("reset_hold_sm", os, rst_val);

        #2 rst_n = 1'b1;
        n = 0;
        running = 1'b1;
        #1;

        foreach (tbl[i]) begin
            guard = 0;
            while (n < tbl[i].n && guard < 5000) begin
                @(negedge clk); #1;
                guard++;
            end
            if (n != tbl[i].n) chk_int($sformatf("tbl%0d_timeout", i), n, tbl[i].n);
            else if (tbl[i].inst == 0) chk($sformatf("tbl%0d_def n=%0d", i, n), od, tbl[i].exp);
            else chk($sformatf("tbl%0d_sm n=%0d", i, n), os, tbl[i].exp);
        end

        chk_int("active_cycles_3frames", act_cnt, 3 * SW * SH);
        chk_int("vsync_low_cycles_3frames", vs_cnt, 3 * SVS * (SW + SHF + SHS + SHB));
        chk_int("screen_end_pulses_3frames", se_cnt, 3);
        chk_int("hsync_low_cycles_line", hs_cnt, 96);

        // Mid-line asynchronous reset: default instance at hCount=300, line 2.
        guard = 0;
        while (n < 1900 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk_int("reach_midline", n, 1900);
        #2;
        running = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_clear_def", od, rst_val);
        chk("async_clear_sm", os, rst_val);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_held_def", od, rst_val);
        chk("reset_held_sm", os, rst_val);

        #2 rst_n = 1'b1;
        n = 0;
        running = 1'b1;
        #1;
        chk("restart_def", od, rst_val);
        @(negedge clk); #1;
        chk_int("restart_x1", int'(xd), 1);
        repeat (60) @(negedge clk);
        running = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_int("queue_drained", qd.size() + qs.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
